// File: rtl/inst_tx_serdy.sv
// DY transmit-path instruction serializer: one IN_W-bit word per frame, emitted
// MSB-first as OUT_W-bit beats with the tail of the final beat masked to length.

module inst_tx_serdy_lane (
  input  logic [7:0] byte_i,
  input  logic       keep_i,
  output logic [7:0] byte_o
);
  assign byte_o = keep_i ? byte_i : 8'h00;
endmodule

module inst_tx_serdy #(
  parameter int U_DLY = 1,
  parameter int IN_W  = 512,
  parameter int OUT_W = 128
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic [15:0]      cfg_ins_length,
  input  logic [IN_W-1:0]  inst_data,
  input  logic             inst_data_valid,
  output logic             inst_ready,
  output logic [OUT_W-1:0] tx_data,
  output logic             tx_data_valid,
  output logic             tx_data_last,
  input  logic             tx_data_ready,
  output logic             len_err
);
  localparam int BEATS_MAX = IN_W / OUT_W;
  localparam int OUT_B     = OUT_W / 8;
  localparam int BW        = $clog2(BEATS_MAX + 1);
  localparam logic [16:0] IN_B17  = 17'(IN_W / 8);
  localparam logic [16:0] OUT_B17 = 17'(OUT_W / 8);

  if ((IN_W % OUT_W) != 0 || (OUT_W % 8) != 0 || U_DLY < 0) begin : g_bad_param
    $error("inst_tx_serdy: IN_W must be a multiple of OUT_W, OUT_W a multiple of 8");
  end

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    sreg_q, sreg_d;
  logic [BW-1:0]      beats_q, beats_d;
  logic [BW-1:0]      idx_q, idx_d;
  logic [OUT_B-1:0]   keep_q, keep_d;
  logic [OUT_W-1:0]   tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               tx_last_q, tx_last_d;
  logic               len_err_q, len_err_d;

  logic               accept;
  logic               len_zero;
  logic               len_bad;
  logic [16:0]        len_eff;
  logic [16:0]        beats17;
  logic [16:0]        lbytes17;
  logic [OUT_B-1:0]   acc_keep;
  logic [OUT_B-1:0]   keep_sel;
  logic [OUT_W-1:0]   nxt_beat;
  logic               nxt_last;
  logic [OUT_W-1:0]   beat_masked;
  logic               xfer;

  assign accept   = (state_q == IDLE) && inst_data_valid;
  assign xfer     = tx_valid_q && tx_data_ready;
  assign len_zero = (cfg_ins_length == 16'd0);
  assign len_bad  = len_zero || ({1'b0, cfg_ins_length} > IN_B17);

  // Frame geometry from the (clamped) length: beat count and valid bytes in the last beat.
  always_comb begin
    len_eff  = ({1'b0, cfg_ins_length} > IN_B17) ? IN_B17 : {1'b0, cfg_ins_length};
    beats17  = (len_eff + OUT_B17 - 17'd1) / OUT_B17;
    lbytes17 = len_eff - (beats17 - 17'd1) * OUT_B17;
    acc_keep = '0;
    for (int j = 0; j < OUT_B; j++) begin
      acc_keep[j] = (17'(j) < lbytes17);
    end
  end

  // The beat being loaded into the output register this cycle (first or next).
  assign nxt_beat = accept ? inst_data[IN_W-1 -: OUT_W] : sreg_q[IN_W-1 -: OUT_W];
  assign nxt_last = accept ? (beats17 == 17'd1) : ((idx_q + BW'(2)) == beats_q);
  assign keep_sel = accept ? acc_keep : keep_q;

  for (genvar j = 0; j < OUT_B; j++) begin : g_lane
    inst_tx_serdy_lane u_lane (
      .byte_i (nxt_beat[OUT_W-1-8*j -: 8]),
      .keep_i (!nxt_last || keep_sel[j]),
      .byte_o (beat_masked[OUT_W-1-8*j -: 8])
    );
  end

  // FSM: state register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !len_zero) state_d = SEND;
      SEND:    if (xfer && tx_last_q)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    inst_ready = (state_q == IDLE);
  end

  // Datapath next-state
  always_comb begin
    sreg_d     = sreg_q;
    beats_d    = beats_q;
    idx_d      = idx_q;
    keep_d     = keep_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    len_err_d  = 1'b0;
    if (accept) begin
      len_err_d = len_bad;
      if (!len_zero) begin
        sreg_d     = inst_data << OUT_W;
        beats_d    = BW'(beats17);
        idx_d      = '0;
        keep_d     = acc_keep;
        tx_data_d  = beat_masked;
        tx_valid_d = 1'b1;
        tx_last_d  = nxt_last;
      end
    end else if (state_q == SEND && xfer) begin
      if (tx_last_q) begin
        tx_data_d  = '0;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
      end else begin
        sreg_d    = sreg_q << OUT_W;
        idx_d     = idx_q + BW'(1);
        tx_data_d = beat_masked;
        tx_last_d = nxt_last;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q     <= '0;
      beats_q    <= '0;
      idx_q      <= '0;
      keep_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      sreg_q     <= sreg_d;
      beats_q    <= beats_d;
      idx_q      <= idx_d;
      keep_q     <= keep_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      len_err_q  <= len_err_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign tx_data_last  = tx_last_q;
  assign len_err       = len_err_q;

endmodule

// File: tb/tb_inst_tx_serdy.sv
// Bench for inst_tx_serdy: vector table of frames scored against a beat queue,
// plus mid-frame reset and a narrow (256/64) parameter build.

module tb_inst_tx_serdy;
  logic         clk_sys = 1'b0;
  logic         rst_n   = 1'b0;
  logic [15:0]  cfg_ins_length = '0;
  logic [511:0] inst_data = '0;
  logic         inst_data_valid = 1'b0;
  logic         inst_ready;
  logic [127:0] tx_data;
  logic         tx_data_valid;
  logic         tx_data_last;
  logic         tx_data_ready = 1'b0;
  logic         len_err;

  logic [15:0]  s_len = '0;
  logic [255:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_inst_ready;
  logic [63:0]  s_tx_data;
  logic         s_tx_valid;
  logic         s_tx_last;
  logic         s_tx_ready = 1'b1;
  logic         s_len_err;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  inst_tx_serdy u_dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .cfg_ins_length(cfg_ins_length),
    .inst_data(inst_data), .inst_data_valid(inst_data_valid), .inst_ready(inst_ready),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_last(tx_data_last),
    .tx_data_ready(tx_data_ready), .len_err(len_err)
  );

  inst_tx_serdy #(.U_DLY(1), .IN_W(256), .OUT_W(64)) u_dut_s (
    .clk_sys(clk_sys), .rst_n(rst_n), .cfg_ins_length(s_len),
    .inst_data(s_data), .inst_data_valid(s_valid), .inst_ready(s_inst_ready),
    .tx_data(s_tx_data), .tx_data_valid(s_tx_valid), .tx_data_last(s_tx_last),
    .tx_data_ready(s_tx_ready), .len_err(s_len_err)
  );

  typedef struct {
    logic [15:0] len;
    int          mode;      // 0 ready always, 1 pattern 1,0,0, 2 random
    logic        exp_err;
    logic        rnd;
    int          exp_beats;
  } vec_t;

  typedef struct {
    logic [127:0] d;
    logic         last;
  } beat_t;

  beat_t sb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] ramp512();
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) r[511-8*k -: 8] = 8'(k);
    return r;
  endfunction

  // Expected beats: byte k of the frame survives only when k < min(len, 64).
  task automatic push_frame(input logic [511:0] d, input logic [15:0] len, input int nb);
    int    le;
    beat_t e;
    le = (len > 16'd64) ? 64 : int'(len);
    for (int b = 0; b < nb; b++) begin
      e.d = '0;
      for (int j = 0; j < 16; j++) begin
        int k;
        k = b * 16 + j;
        e.d[127-8*j -: 8] = (k < le) ? d[511-8*k -: 8] : 8'h00;
      end
      e.last = (b == nb - 1);
      sb.push_back(e);
    end
  endtask

  task automatic run_vec(input vec_t v, input int abort_after);
    logic [511:0] d;
    logic [127:0] prev_d;
    logic         prev_last, prev_hold, rdy;
    int           n, cyc, popped;
    beat_t        e;
    if (v.rnd) for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom();
    else       d = ramp512();
    n = 0;
    while (!inst_ready && n < 50) begin @(negedge clk_sys); n++; end
    chk("ready_before_accept", 128'(inst_ready), 128'(1));
    inst_data = d; cfg_ins_length = v.len; inst_data_valid = 1'b1; tx_data_ready = 1'b0;
    @(posedge clk_sys);
    push_frame(d, v.len, v.exp_beats);
    @(negedge clk_sys);
    inst_data_valid = 1'b0; inst_data = ~d; cfg_ins_length = 16'hFFFF;
    chk("len_err_n1", 128'(len_err), 128'(v.exp_err));
    chk("first_valid_n1", 128'(tx_data_valid), 128'(v.exp_beats != 0));
    if (v.exp_beats == 0) begin
      chk("zero_len_ready", 128'(inst_ready), 128'(1));
      @(negedge clk_sys);
      chk("zero_len_err_drop", 128'(len_err), 128'(0));
      chk("zero_len_no_valid", 128'(tx_data_valid), 128'(0));
      return;
    end
    cyc = 0; popped = 0; prev_hold = 1'b0; prev_d = '0; prev_last = 1'b0;
    while (sb.size() > 0 && cyc < 200) begin
      if (abort_after >= 0 && popped == abort_after) break;
      if (prev_hold) begin
        chk("hold_data", tx_data, prev_d);
        chk("hold_valid", 128'(tx_data_valid), 128'(1));
        chk("hold_last", 128'(tx_data_last), 128'(prev_last));
      end
      case (v.mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tx_data_ready = rdy;
      if (tx_data_valid && rdy) begin
        e = sb.pop_front();
        popped++;
        chk("beat_data", tx_data, e.d);
        chk("beat_last", 128'(tx_data_last), 128'(e.last));
      end
      prev_hold = tx_data_valid && !rdy; prev_d = tx_data; prev_last = tx_data_last;
      @(negedge clk_sys);
      cyc++;
    end
    if (abort_after >= 0) return;
    if (sb.size() != 0) begin
      chk("frame_timeout", 128'(sb.size()), 128'(0));
      sb.delete();
    end
    if (v.mode == 0) chk("frame_cycles", 128'(cyc), 128'(v.exp_beats));
    tx_data_ready = 1'b0;
    chk("end_valid_drop", 128'(tx_data_valid), 128'(0));
    chk("end_last_drop", 128'(tx_data_last), 128'(0));
    chk("end_ready", 128'(inst_ready), 128'(1));
    chk("end_len_err", 128'(len_err), 128'(0));
  endtask

  vec_t vecs[10];

  initial begin
    vec_t         rv;
    logic [255:0] r256;
    logic [63:0]  es;
    int           n, got;

    vecs = '{
      '{16'd64,  0, 1'b0, 1'b0, 4},
      '{16'd20,  0, 1'b0, 1'b0, 2},
      '{16'd64,  1, 1'b0, 1'b0, 4},
      '{16'd0,   0, 1'b1, 1'b0, 0},
      '{16'd100, 0, 1'b1, 1'b0, 4},
      '{16'd16,  0, 1'b0, 1'b1, 1},
      '{16'd17,  2, 1'b0, 1'b1, 2},
      '{16'd48,  2, 1'b0, 1'b1, 3},
      '{16'd1,   0, 1'b0, 1'b1, 1},
      '{16'd65,  1, 1'b1, 1'b1, 4}
    };

    repeat (3) @(negedge clk_sys);
    chk("rst_valid", 128'(tx_data_valid), 128'(0));
    chk("rst_last", 128'(tx_data_last), 128'(0));
    chk("rst_data", tx_data, 128'(0));
    chk("rst_len_err", 128'(len_err), 128'(0));
    chk("rst_ready", 128'(inst_ready), 128'(1));
    rst_n = 1'b1;
    @(negedge clk_sys);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], -1);

    // Mid-frame reset after two beats have transferred
    rv = '{16'd64, 0, 1'b0, 1'b0, 4};
    run_vec(rv, 2);
    @(posedge clk_sys);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 128'(tx_data_valid), 128'(0));
    chk("midrst_last", 128'(tx_data_last), 128'(0));
    chk("midrst_data", tx_data, 128'(0));
    chk("midrst_ready", 128'(inst_ready), 128'(1));
    sb.delete();
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    tx_data_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_sys);
      chk("postrst_no_beat", 128'(tx_data_valid), 128'(0));
    end
    chk("postrst_ready", 128'(inst_ready), 128'(1));
    tx_data_ready = 1'b0;

    // Narrow build: 256-bit word, 64-bit beats, len=32
    r256 = '0;
    for (int k = 0; k < 32; k++) r256[255-8*k -: 8] = 8'(8'h40 + k);
    n = 0;
    while (!s_inst_ready && n < 50) begin @(negedge clk_sys); n++; end
    s_data = r256; s_len = 16'd32; s_valid = 1'b1;
    @(negedge clk_sys);
    s_valid = 1'b0; s_data = '0;
    chk("s_len_err", 128'(s_len_err), 128'(0));
    got = 0; n = 0;
    while (got < 4 && n < 50) begin
      if (s_tx_valid) begin
        for (int j = 0; j < 8; j++) es[63-8*j -: 8] = 8'(8'h40 + got * 8 + j);
        chk("s_beat_data", 128'(s_tx_data), 128'(es));
        chk("s_beat_last", 128'(s_tx_last), 128'(got == 3));
        got++;
      end
      @(negedge clk_sys);
      n++;
    end
    chk("s_beat_count", 128'(got), 128'(4));
    chk("s_valid_drop", 128'(s_tx_valid), 128'(0));
    chk("s_ready_back", 128'(s_inst_ready), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_tx_serdy.md
Name: inst_tx_serdy

Overview:
- Parametrised instruction serializer for the DY transmit path.
- Accepts one wide instruction word (default 512 bits) per frame.
- Emits the word MSB-first as OUT_W-bit beats under a valid/ready handshake.
- Beat count is set by cfg_ins_length; bytes beyond the configured length are masked to zero; frame end is flagged.

Parameters:
- U_DLY, 1, register assignment delay (simulation only).
- IN_W, 512, input instruction width in bits; must be a multiple of OUT_W.
- OUT_W, 128, output beat width in bits; must be a multiple of 8.
- BEATS_MAX, derived IN_W/OUT_W (4 at defaults), maximum beats per frame; not overridable.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_ins_length  in  16  instruction length in bytes; sampled at frame accept.
- inst_data  in  IN_W  instruction word; bit IN_W-1 is the first transmitted bit.
- inst_data_valid  in  1  inst_data is valid.
- inst_ready  out  1  block can accept a frame.
- tx_data  out  OUT_W  current output beat.
- tx_data_valid  out  1  tx_data is valid.
- tx_data_last  out  1  current beat is the final beat of the frame.
- tx_data_ready  in  1  downstream accepts the beat.
- len_err  out  1  one-cycle pulse: cfg_ins_length was 0 or exceeded IN_W/8 at accept.

Behaviour:
- Reset: state=IDLE; tx_data=0, tx_data_valid=0, tx_data_last=0, len_err=0; shift register and beat counter cleared. Reset asserted mid-frame aborts the frame immediately; no partial beats follow reset release.
- inst_ready = 1 only in IDLE; it is decoded from the state register.
- Accept: inst_data_valid && inst_ready in cycle N latches inst_data and cfg_ins_length.
  - beats = ceil(len*8/OUT_W).
  - len > IN_W/8: clamp to BEATS_MAX, pulse len_err in N+1, transmit.
  - len = 0: pulse len_err in N+1, transmit nothing, stay IDLE (inst_ready stays 1).
- First beat: tx_data_valid=1 in cycle N+1 with tx_data = inst_data[IN_W-1 -: OUT_W]. Fixed latency is 1 cycle.
- States:
  - IDLE -> SEND on accept with len != 0.
  - SEND: a beat transfers when tx_data_valid && tx_data_ready. The next beat (the next lower OUT_W slice) is presented in the following cycle with no bubble.
  - SEND -> IDLE on the transfer of the beat with tx_data_last=1. tx_data_valid and tx_data_last drop in the next cycle; inst_ready=1 in that cycle.
- Back-to-back frames: minimum one idle cycle between the last beat transfer and the next accept, so a frame occupies at least beats+1 cycles.
- Backpressure: while tx_data_valid && !tx_data_ready, tx_data, tx_data_valid and tx_data_last hold stable.
- tx_data_last = 1 only on beat index beats-1. If beats=1, it is set on the first beat.
- Masking: on the last beat, bytes at frame byte offset >= len are forced to 0. Byte 0 is inst_data[IN_W-1:IN_W-8]. Non-final beats are unmasked.
- cfg_ins_length and inst_data changes during SEND have no effect on the current frame.
- All outputs except inst_ready are registered.

Test Plan:
- Reset, then len=64, inst_data = 512'h00..3F byte ramp (byte k = k), tx_data_ready=1 -> 4 consecutive beats starting 1 cycle after accept: 128'h000102..0F, 101112..1F, 202122..2F, 303132..3F. tx_data_last on beat 4; inst_ready returns 1 after 5 cycles.
- len=20, same data -> 2 beats: beat0 = bytes 00..0F; beat1 = 128'h10111213 followed by 96 zero bits; tx_data_last on beat1; len_err=0.
- len=64, tx_data_ready toggles 1,0,0,1,... -> each beat is held unchanged while ready=0; no beat is lost or duplicated; still 4 beats total.
- len=0 -> len_err pulses 1 cycle; tx_data_valid stays 0; inst_ready stays 1. len=100 -> len_err pulses; 4 beats sent unmasked.
- rst_n asserted after beat 2 of a 4-beat frame -> all outputs are 0 the same cycle. After release, inst_ready=1 and no residual beats appear.
- Parameter build IN_W=256, OUT_W=64, len=32 -> 4 beats of 64 bits, MSB-first, last flagged on beat 4.
